// File: rtl/timer_core_mc.sv
// Multi-channel machine timer: prescaled mtime timebase driving N level/periodic compare channels.
// Optional sticky overflow flag (ports ovf_clr/ovf) enabled by defining TIMER_CORE_MC_OVF_EN.
module timer_core_mc #(
  parameter int N  = 1,
  parameter int CW = 64,
  parameter int PW = 12,
  parameter int SW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            active,
  input  logic [PW-1:0]   prescaler,
  input  logic [SW-1:0]   step,
  output logic            tick,
  input  logic            mtime_we,
  input  logic [CW-1:0]   mtime_wdata,
  output logic [CW-1:0]   mtime,
  input  logic [N-1:0]    cmp_we,
  input  logic [CW-1:0]   cmp_wdata,
  input  logic [N-1:0]    period_we,
  input  logic [CW-1:0]   period_wdata,
  input  logic [N-1:0]    mode,
  input  logic [N-1:0]    intr_clr,
  output logic [N*CW-1:0] mtimecmp,
  output logic [N-1:0]    intr
`ifdef TIMER_CORE_MC_OVF_EN
  ,
  input  logic            ovf_clr,
  output logic            ovf
`endif
);

  logic [PW-1:0] tick_count_r;
  logic [PW-1:0] tick_count_nxt_s;
  logic          tick_s;
  logic [CW-1:0] mtime_r;
  logic [CW-1:0] mtime_nxt_s;
`ifdef TIMER_CORE_MC_OVF_EN
  logic [CW:0]   mtime_sum_s;
  logic          ovf_r;
  logic          ovf_nxt_s;
`else
  logic [CW-1:0] mtime_sum_s;
`endif

  logic [CW-1:0] cmp_r       [N];
  logic [CW-1:0] cmp_nxt_s   [N];
  logic [CW-1:0] period_r    [N];
  logic [N-1:0]  status_r;
  logic [N-1:0]  status_nxt_s;
  logic [N-1:0]  hit_s;
  logic [N-1:0]  intr_s;

  // Prescaler: restart on every tick so a lowered divisor ticks once and then resumes normally
  always_comb begin
    tick_s           = active & (tick_count_r >= prescaler);
    tick_count_nxt_s = tick_count_r;
    if (!active) begin
      tick_count_nxt_s = {PW{1'b0}};
    end else if (tick_s) begin
      tick_count_nxt_s = {PW{1'b0}};
    end else begin
      tick_count_nxt_s = tick_count_r + PW'(1'b1);
    end
  end

  // mtime next value: software load beats a coincident tick
  always_comb begin
`ifdef TIMER_CORE_MC_OVF_EN
    mtime_sum_s = {1'b0, mtime_r} + {1'b0, CW'(step)};
`else
    mtime_sum_s = mtime_r + CW'(step);
`endif
    mtime_nxt_s = mtime_r;
    if (mtime_we) begin
      mtime_nxt_s = mtime_wdata;
    end else if (tick_s) begin
      mtime_nxt_s = mtime_sum_s[CW-1:0];
    end else begin
      mtime_nxt_s = mtime_r;
    end
  end

`ifdef TIMER_CORE_MC_OVF_EN
  // Sticky overflow: only a tick-driven carry sets it, and set wins over clear
  always_comb begin
    ovf_nxt_s = ovf_r;
    if (tick_s & ~mtime_we & mtime_sum_s[CW]) begin
      ovf_nxt_s = 1'b1;
    end else if (ovf_clr) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // Overflow flag register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_nxt_s;
    end
  end

  assign ovf = ovf_r;
`endif

  // Per-channel compare, auto-advance and sticky status
  always_comb begin
    hit_s        = {N{1'b0}};
    intr_s       = {N{1'b0}};
    status_nxt_s = {N{1'b0}};
    mtimecmp     = {(N*CW){1'b0}};
    for (int i = 0; i < N; i++) begin
      cmp_nxt_s[i] = cmp_r[i];
      hit_s[i]     = active & (mtime_r >= cmp_r[i]);

      // a direct write overrides the auto-advance; a zero period means one-shot
      if (cmp_we[i]) begin
        cmp_nxt_s[i] = cmp_wdata;
      end else if (mode[i] & hit_s[i]) begin
        if (period_r[i] != {CW{1'b0}}) begin
          cmp_nxt_s[i] = cmp_r[i] + period_r[i];
        end else begin
          cmp_nxt_s[i] = {CW{1'b1}};
        end
      end else begin
        cmp_nxt_s[i] = cmp_r[i];
      end

      if (!mode[i]) begin
        status_nxt_s[i] = 1'b0;
      end else if (hit_s[i]) begin
        status_nxt_s[i] = 1'b1;
      end else if (intr_clr[i]) begin
        status_nxt_s[i] = 1'b0;
      end else begin
        status_nxt_s[i] = status_r[i];
      end

      if (mode[i]) begin
        intr_s[i] = status_r[i] & active;
      end else begin
        intr_s[i] = hit_s[i];
      end

      mtimecmp[i*CW +: CW] = cmp_r[i];
    end
  end

  // Timebase and channel state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_count_r <= {PW{1'b0}};
      mtime_r      <= {CW{1'b0}};
      status_r     <= {N{1'b0}};
      for (int i = 0; i < N; i++) begin
        cmp_r[i]    <= {CW{1'b1}};
        period_r[i] <= {CW{1'b0}};
      end
    end else begin
      tick_count_r <= tick_count_nxt_s;
      mtime_r      <= mtime_nxt_s;
      status_r     <= status_nxt_s;
      for (int i = 0; i < N; i++) begin
        cmp_r[i] <= cmp_nxt_s[i];
        if (period_we[i]) begin
          period_r[i] <= period_wdata;
        end else begin
          period_r[i] <= period_r[i];
        end
      end
    end
  end

  assign tick  = tick_s;
  assign mtime = mtime_r;
  assign intr  = intr_s;

endmodule

// File: tb/tb_timer_core_mc.sv
// Directed bench for timer_core_mc (N=4, CW=16): spec-level model checked every cycle plus literal pins.
module tb_timer_core_mc;

  localparam int N  = 4;
  localparam int CW = 16;
  localparam int PW = 12;
  localparam int SW = 8;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            active = 1'b0;
  logic [PW-1:0]   prescaler = '0;
  logic [SW-1:0]   step = '0;
  logic            tick;
  logic            mtime_we = 1'b0;
  logic [CW-1:0]   mtime_wdata = '0;
  logic [CW-1:0]   mtime;
  logic [N-1:0]    cmp_we = '0;
  logic [CW-1:0]   cmp_wdata = '0;
  logic [N-1:0]    period_we = '0;
  logic [CW-1:0]   period_wdata = '0;
  logic [N-1:0]    mode = '0;
  logic [N-1:0]    intr_clr = '0;
  logic [N*CW-1:0] mtimecmp;
  logic [N-1:0]    intr;
  logic            ovf_clr = 1'b0;
`ifdef TIMER_CORE_MC_OVF_EN
  logic            ovf;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model state, plain integers
  int m_cnt;
  int m_mtime;
  int m_cmp [N];
  int m_per [N];
  bit [N-1:0] m_stat;
  bit m_ovf;

  timer_core_mc #(.N(N), .CW(CW), .PW(PW), .SW(SW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .active(active), .prescaler(prescaler),
    .step(step), .tick(tick), .mtime_we(mtime_we), .mtime_wdata(mtime_wdata),
    .mtime(mtime), .cmp_we(cmp_we), .cmp_wdata(cmp_wdata), .period_we(period_we),
    .period_wdata(period_wdata), .mode(mode), .intr_clr(intr_clr),
    .mtimecmp(mtimecmp), .intr(intr)
`ifdef TIMER_CORE_MC_OVF_EN
    , .ovf_clr(ovf_clr), .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_tick();
    return active && (m_cnt >= int'(prescaler));
  endfunction

  function automatic bit m_hit(input int i);
    return active && (m_mtime >= m_cmp[i]);
  endfunction

  function automatic bit m_intr(input int i);
    return mode[i] ? (m_stat[i] && active) : m_hit(i);
  endfunction

  // reference model update
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_cnt   <= 0;
      m_mtime <= 0;
      m_ovf   <= 1'b0;
      m_stat  <= '0;
      for (int i = 0; i < N; i++) begin
        m_cmp[i] <= 65535;
        m_per[i] <= 0;
      end
    end else begin
      m_cnt <= (!active || m_tick()) ? 0 : m_cnt + 1;
      if (mtime_we) m_mtime <= int'(mtime_wdata);
      else if (m_tick()) m_mtime <= (m_mtime + int'(step)) % 65536;
      if (!mtime_we && m_tick() && (m_mtime + int'(step) >= 65536)) m_ovf <= 1'b1;
      else if (ovf_clr) m_ovf <= 1'b0;
      for (int i = 0; i < N; i++) begin
        if (cmp_we[i]) m_cmp[i] <= int'(cmp_wdata);
        else if (mode[i] && m_hit(i))
          m_cmp[i] <= (m_per[i] == 0) ? 65535 : (m_cmp[i] + m_per[i]) % 65536;
        if (period_we[i]) m_per[i] <= int'(period_wdata);
        m_stat[i] <= mode[i] && (m_hit(i) || (m_stat[i] && !intr_clr[i]));
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tick", tick, m_tick());
      chk("mtime", mtime, m_mtime);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("cmp%0d", i), mtimecmp[i*CW +: CW], m_cmp[i]);
        chk($sformatf("intr%0d", i), intr[i], m_intr(i));
      end
`ifdef TIMER_CORE_MC_OVF_EN
      chk("ovf", ovf, m_ovf);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    cyc(2);
    chk("rst_mtime", mtime, 16'h0000);
    chk("rst_cmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_intr", intr, 4'b0000);
    chk("rst_tick", tick, 1'b0);
    rst_ni = 1'b1;
    chk_en = 1'b1;

    // prescaler 3, step 5
    active = 1'b1; prescaler = 12'd3; step = 8'd5;
    cyc(4); chk("ps_mtime5", mtime, 16'd5);
    cyc(4); chk("ps_mtime10", mtime, 16'd10);
    cyc(4); chk("ps_mtime15", mtime, 16'd15);
    active = 1'b0;
    cyc(3); chk("hold_mtime", mtime, 16'd15); chk("hold_tick", tick, 1'b0);

    // prescaler lowered below the running count
    active = 1'b1; prescaler = 12'd7;
    cyc(5); prescaler = 12'd2;
    cyc(6); active = 1'b0;
    cyc(1);

    // level mode on channel 0
    prescaler = 12'd0; step = 8'd1; active = 1'b1;
    mtime_we = 1'b1; mtime_wdata = 16'd0; cmp_we = 4'b0001; cmp_wdata = 16'd20;
    cyc(1); mtime_we = 1'b0; cmp_we = 4'b0000;
    chk("lvl_mtime0", mtime, 16'd0);
    cyc(20); chk("lvl_mtime20", mtime, 16'd20); chk("lvl_rise", intr[0], 1'b1);
    cmp_we = 4'b0001; cmp_wdata = 16'd100;
    cyc(1); cmp_we = 4'b0000;
    chk("lvl_fall", intr[0], 1'b0); chk("lvl_cmp100", mtimecmp[15:0], 16'd100);

    // periodic mode on channel 1
    mtime_we = 1'b1; mtime_wdata = 16'd0; mode = 4'b0010;
    cmp_we = 4'b0010; cmp_wdata = 16'd10; period_we = 4'b0010; period_wdata = 16'd10;
    cyc(1); mtime_we = 1'b0; cmp_we = 4'b0000; period_we = 4'b0000;
    cyc(10);
    cyc(1); chk("per_cmp20", mtimecmp[31:16], 16'd20); chk("per_set", intr[1], 1'b1);
    cyc(4); intr_clr = 4'b0010;
    cyc(1); intr_clr = 4'b0000; chk("per_clr", intr[1], 1'b0);
    cyc(4); intr_clr = 4'b0010;
    cyc(1); intr_clr = 4'b0000;
    chk("per_setwins", intr[1], 1'b1); chk("per_cmp30", mtimecmp[31:16], 16'd30);
    mtime_we = 1'b1; mtime_wdata = 16'd55;
    cyc(1); mtime_we = 1'b0;
    cyc(4); chk("per_catchup", mtimecmp[31:16], 16'd60); chk("per_sticky", intr[1], 1'b1);
    mode = 4'b0000;
    cyc(2);

    // one-shot on channel 2, then load priority
    mode = 4'b0100; mtime_we = 1'b1; mtime_wdata = 16'd0;
    cmp_we = 4'b0100; cmp_wdata = 16'd8;
    cyc(1); mtime_we = 1'b0; cmp_we = 4'b0000;
    cyc(8);
    cyc(1); chk("os_cmp", mtimecmp[47:32], 16'hFFFF); chk("os_intr", intr[2], 1'b1);
    cyc(3);
    mtime_we = 1'b1; mtime_wdata = 16'd7;
    cyc(1); mtime_we = 1'b0; chk("load_prio", mtime, 16'd7);

    // four channels, mixed modes
    mode = 4'b1010; mtime_we = 1'b1; mtime_wdata = 16'd0; intr_clr = 4'b1111;
    period_we = 4'b1111; period_wdata = 16'd100;
    for (int i = 0; i < N; i++) begin
      cmp_we = 4'b0001 << i; cmp_wdata = 16'(5 * (i + 1));
      cyc(1);
      period_we = 4'b0000;
    end
    mtime_we = 1'b0; cmp_we = 4'b0000; intr_clr = 4'b0000;
    cyc(12); chk("mc_intr12", intr, 4'b0011); chk("mc_cmp1", mtimecmp[31:16], 16'd110);
    cyc(10); chk("mc_intr22", intr, 4'b1111);

    // wrap with step 3
    mtime_we = 1'b1; mtime_wdata = 16'hFFFE; step = 8'd3;
    cyc(1); mtime_we = 1'b0; chk("wrap_load", mtime, 16'hFFFE);
    cyc(1); chk("wrap", mtime, 16'h0001);
`ifdef TIMER_CORE_MC_OVF_EN
    chk("ovf_set", ovf, 1'b1);
    cyc(2); chk("ovf_sticky", ovf, 1'b1);
    ovf_clr = 1'b1;
    cyc(1); ovf_clr = 1'b0; chk("ovf_clr", ovf, 1'b0);
`endif
    cyc(3);

    // asynchronous reset mid-operation
    rst_ni = 1'b0;
    #1;
    chk("arst_mtime", mtime, 16'h0000);
    chk("arst_cmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("arst_intr", intr, 4'b0000);
    cyc(1); rst_ni = 1'b1;
    cyc(5);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
